// File: rtl/z_state_estimator.sv
// z_state_estimator: turns raw vertical-position samples into a moving-average
// z_pos and a saturated finite-difference z_vel. A watchdog on the sample
// strobe raises sensor_fault and zeroes z_vel when the sensor goes quiet.
module z_state_estimator #(
  parameter int AVG_LOG2       = 2,
  parameter int VEL_SHIFT      = 0,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_valid,
  input  logic signed [15:0] sample_data,
  output logic signed [15:0] z_pos,
  output logic signed [15:0] z_vel,
  output logic               state_valid,
  output logic               warm,
  output logic               sensor_fault
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = 16 + AVG_LOG2;
  localparam int VW = 17 + VEL_SHIFT;

  localparam logic signed [VW-1:0] VEL_MAX = VW'(32'sd32767);
  localparam logic signed [VW-1:0] VEL_MIN = VW'(-32'sd32768);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic signed [15:0]     win_r [N];
  logic signed [SW-1:0]   sum_r;
  logic [4:0]             fill_cnt_r;
  logic [31:0]            wd_r;
  logic                   upd_r;
  logic                   first_r;
  logic signed [15:0]     prev_r;

  logic [4:0]             fill_base_s;
  logic                   fill_last_s;
  logic                   wd_hit_s;
  logic signed [SW-1:0]   samp_ext_s;
  logic signed [SW-1:0]   oldest_ext_s;
  logic signed [SW-1:0]   sum_nxt_s;
  logic signed [15:0]     mean_s;
  logic signed [16:0]     diff_s;
  logic signed [VW-1:0]   vel_sh_s;

  // Clamp the scaled velocity difference into the 16-bit output range.
  function automatic logic signed [15:0] sat16(input logic signed [VW-1:0] v);
    if (v > VEL_MAX) begin
      sat16 = 16'sh7FFF;
    end else if (v < VEL_MIN) begin
      sat16 = 16'sh8000;
    end else begin
      sat16 = 16'(v);
    end
  endfunction

  // A FAULT sample restarts the fill at one, so the count base is zero there.
  assign fill_base_s  = (state_r == ST_FAULT) ? 5'd0 : fill_cnt_r;
  assign fill_last_s  = ((fill_base_s + 5'd1) == 5'(N));
  assign wd_hit_s     = ((wd_r + 32'd1) == 32'(TIMEOUT_CYCLES));
  assign samp_ext_s   = SW'(sample_data);
  assign oldest_ext_s = SW'(win_r[N-1]);
  assign sum_nxt_s    = sum_r + samp_ext_s - oldest_ext_s;
  assign mean_s       = 16'(sum_r >>> AVG_LOG2);
  assign diff_s       = $signed({mean_s[15], mean_s}) - $signed({prev_r[15], prev_r});
  assign vel_sh_s     = VW'(diff_s) <<< VEL_SHIFT;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: fill completion, watchdog timeout, fault recovery.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FILL: begin
        if (sample_valid && fill_last_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_RUN: begin
        if (!sample_valid && wd_hit_s) begin
          state_nxt_s = ST_FAULT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (sample_valid) begin
          state_nxt_s = fill_last_s ? ST_RUN : ST_FILL;
        end else begin
          state_nxt_s = ST_FAULT;
        end
      end
      default: begin
        state_nxt_s = ST_FILL;
      end
    endcase
  end

  // Sample window, running sum and fill count; a FAULT sample reseeds them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) win_r[i] <= '0;
      sum_r      <= '0;
      fill_cnt_r <= 5'd0;
    end else if (sample_valid) begin
      if (state_r == ST_FAULT) begin
        for (int i = 1; i < N; i++) win_r[i] <= '0;
        win_r[0]   <= sample_data;
        sum_r      <= samp_ext_s;
        fill_cnt_r <= 5'd1;
      end else begin
        for (int i = N - 1; i > 0; i--) win_r[i] <= win_r[i-1];
        win_r[0] <= sample_data;
        sum_r    <= sum_nxt_s;
        if (state_r == ST_FILL) begin
          fill_cnt_r <= fill_cnt_r + 5'd1;
        end
      end
    end
  end

  // Watchdog: counts sample-free cycles in RUN only; a sample always clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_r <= 32'd0;
    end else if (state_r == ST_RUN && !sample_valid && !wd_hit_s) begin
      wd_r <= wd_r + 32'd1;
    end else begin
      wd_r <= 32'd0;
    end
  end

  // Pipeline flags: the sum just updated should produce an output next edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_r   <= 1'b0;
      first_r <= 1'b0;
    end else begin
      upd_r   <= sample_valid && ((state_r == ST_RUN) || fill_last_s);
      first_r <= sample_valid && (state_r != ST_RUN) && fill_last_s;
    end
  end

  // Output stage: register mean/velocity, or apply the fault-entry overrides.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z_pos        <= 16'sd0;
      z_vel        <= 16'sd0;
      prev_r       <= 16'sd0;
      state_valid  <= 1'b0;
      warm         <= 1'b0;
      sensor_fault <= 1'b0;
    end else if (upd_r) begin
      state_valid <= 1'b1;
      z_pos       <= mean_s;
      prev_r      <= mean_s;
      if (first_r) begin
        z_vel        <= 16'sd0;
        warm         <= 1'b1;
        sensor_fault <= 1'b0;
      end else begin
        z_vel <= sat16(vel_sh_s);
      end
    end else if (state_r == ST_RUN && state_nxt_s == ST_FAULT) begin
      state_valid  <= 1'b0;
      z_vel        <= 16'sd0;
      warm         <= 1'b0;
      sensor_fault <= 1'b1;
    end else begin
      state_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_z_state_estimator.sv
// Directed bench for z_state_estimator: three instances share one stimulus
// stream (defaults, VEL_SHIFT=2, TIMEOUT_CYCLES=20); each test resets all.
module tb_z_state_estimator;

  logic               clk;
  logic               rst_n;
  logic               sample_valid;
  logic signed [15:0] sample_data;

  logic signed [15:0] pos0, vel0, pos1, vel1, pos2, vel2;
  logic               sv0, warm0, sf0, sv1, warm1, sf1, sv2, warm2, sf2;

  int n_checks = 0;
  int n_errors = 0;

  z_state_estimator u_def (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .z_pos(pos0), .z_vel(vel0), .state_valid(sv0), .warm(warm0), .sensor_fault(sf0)
  );

  z_state_estimator #(.VEL_SHIFT(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .z_pos(pos1), .z_vel(vel1), .state_valid(sv1), .warm(warm1), .sensor_fault(sf1)
  );

  z_state_estimator #(.TIMEOUT_CYCLES(20)) u_wd (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .z_pos(pos2), .z_vel(vel2), .state_valid(sv2), .warm(warm2), .sensor_fault(sf2)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_data  = 16'sd0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Present one sample for exactly one clock edge.
  task automatic drive(input logic signed [15:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    tick();
    sample_valid = 1'b0;
  endtask

  // Directed tests.
  initial begin
    logic signed [15:0] ramp [4];
    int exp_pos [5];
    int exp_vel [5];
    int sat_pos [4];
    ramp    = '{16'sd104, 16'sd108, 16'sd112, 16'sd116};
    exp_pos = '{100, 101, 103, 106, 110};
    exp_vel = '{0, 1, 2, 3, 4};
    sat_pos = '{-16385, -1, 16383, 32767};

    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_data  = 16'sd0;

    // 1. Reset held with sample_valid toggling.
    for (int i = 0; i < 10; i++) begin
      sample_valid = i[0];
      sample_data  = 16'sd100;
      tick();
      check_val("rst_pos", pos0, 0);
      check_val("rst_vel", vel0, 0);
      check_val("rst_sv", sv0, 0);
      check_val("rst_warm", warm0, 0);
      check_val("rst_fault", sf0, 0);
    end

    // 2. Fill with 100, one sample every 4 cycles.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(16'sd100);
      for (int k = 0; k < 3; k++) begin
        tick();
        check_val("fill_sv", sv0, 0);
      end
    end
    drive(16'sd100);
    check_val("fill4_sv_lat1", sv0, 0);
    check_val("fill4_warm_lat1", warm0, 0);
    tick();
    check_val("fill4_sv", sv0, 1);
    check_val("fill4_pos", pos0, 100);
    check_val("fill4_vel", vel0, 0);
    check_val("fill4_warm", warm0, 1);
    tick();
    check_val("fill4_sv_pulse", sv0, 0);
    tick();

    // 3a. Ramp, spaced samples.
    for (int i = 0; i < 4; i++) begin
      drive(ramp[i]);
      tick();
      check_val("ramp_sv", sv0, 1);
      check_val("ramp_pos", pos0, exp_pos[i+1]);
      check_val("ramp_vel", vel0, exp_vel[i+1]);
      tick();
      check_val("ramp_hold_pos", pos0, exp_pos[i+1]);
      tick();
    end

    // 3b. Same sequence back-to-back.
    do_reset();
    for (int j = 0; j < 8; j++) begin
      drive(j < 4 ? 16'sd100 : ramp[j-4]);
      if (j >= 4) begin
        check_val("b2b_sv", sv0, 1);
        check_val("b2b_pos", pos0, exp_pos[j-4]);
        check_val("b2b_vel", vel0, exp_vel[j-4]);
      end else begin
        check_val("b2b_fill_sv", sv0, 0);
      end
    end
    tick();
    check_val("b2b_last_sv", sv0, 1);
    check_val("b2b_last_pos", pos0, 110);
    check_val("b2b_last_vel", vel0, 4);
    tick();
    check_val("b2b_end_sv", sv0, 0);

    // 4. Negative rounding: floor(-7/4) = -2.
    do_reset();
    drive(-16'sd1);
    drive(-16'sd2);
    drive(-16'sd2);
    drive(-16'sd2);
    tick();
    check_val("neg_sv", sv0, 1);
    check_val("neg_pos", pos0, -2);
    check_val("neg_vel", vel0, 0);

    // 5. Saturation: full-scale step with VEL_SHIFT=2.
    do_reset();
    for (int i = 0; i < 4; i++) drive(-16'sd32768);
    tick();
    check_val("sat_first_pos", pos1, -32768);
    check_val("sat_first_vel", vel1, 0);
    for (int i = 0; i < 4; i++) begin
      drive(16'sd32767);
      tick();
      check_val("sat_sv", sv1, 1);
      check_val("sat_vel", vel1, 32767);
      check_val("sat_pos", pos1, sat_pos[i]);
      if (i == 0) check_val("noshift_vel", vel0, 16383);
    end

    // 6a. Watchdog timeout after a ramp step.
    do_reset();
    for (int i = 0; i < 4; i++) drive(16'sd10);
    drive(16'sd30);
    tick();
    check_val("wd_sv", sv2, 1);
    check_val("wd_pos", pos2, 15);
    check_val("wd_vel", vel2, 5);
    idle(18);
    check_val("wd_pre_fault", sf2, 0);
    check_val("wd_pre_warm", warm2, 1);
    check_val("wd_pre_vel", vel2, 5);
    tick();
    check_val("wd_fault", sf2, 1);
    check_val("wd_fault_warm", warm2, 0);
    check_val("wd_fault_vel", vel2, 0);
    check_val("wd_fault_pos", pos2, 15);
    check_val("wd_fault_sv", sv2, 0);
    idle(5);
    check_val("wd_fault_hold", sf2, 1);

    // 6b. Recovery: re-fill with 50, fault holds until first output.
    for (int i = 0; i < 3; i++) begin
      drive(16'sd50);
      tick();
      check_val("refill_fault", sf2, 1);
      check_val("refill_sv", sv2, 0);
      tick();
    end
    drive(16'sd50);
    tick();
    check_val("rec_sv", sv2, 1);
    check_val("rec_pos", pos2, 50);
    check_val("rec_vel", vel2, 0);
    check_val("rec_fault", sf2, 0);
    check_val("rec_warm", warm2, 1);

    // 6c. Sample lands exactly when the watchdog would expire.
    idle(18);
    drive(16'sd50);
    check_val("edge_no_fault", sf2, 0);
    tick();
    check_val("edge_sv", sv2, 1);
    check_val("edge_fault_after", sf2, 0);
    idle(18);
    check_val("edge_restart_pre", sf2, 0);
    tick();
    check_val("edge_restart_fault", sf2, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/z_state_estimator.md
Name: z_state_estimator

Overview:
Upstream stage of reflex_core. Converts raw vertical-position sensor samples into the filtered z_pos and finite-difference z_vel words that the PD/guardian controller consumes. It has a power-of-two moving-average window, a saturating velocity path and a stale-sensor watchdog. On a watchdog timeout it raises sensor_fault and forces z_vel to zero, so the controller never acts on a frozen derivative.

Parameters:
AVG_LOG2, 2, log2 of moving-average window depth N (N = 2^AVG_LOG2, legal 0..4)
VEL_SHIFT, 0, left shift applied to the velocity difference (sample-rate scaling, legal 0..4)
TIMEOUT_CYCLES, 1000, clk cycles without sample_valid in RUN before FAULT is entered (legal >= 2)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
sample_valid  in  1  one-cycle strobe; sample_data is valid this cycle
sample_data  in  16  signed raw position sample
z_pos  out  16  signed filtered position (to reflex_core z_pos)
z_vel  out  16  signed filtered velocity (to reflex_core z_vel)
state_valid  out  1  one-cycle pulse when z_pos/z_vel update
warm  out  1  high while in RUN (window full, outputs meaningful)
sensor_fault  out  1  high in FAULT and in the re-FILL after a FAULT

Behaviour:
- Reset (rst_n=0 at a clk edge): highest priority over all other logic, including mid-operation. State goes to FILL. Window registers, running sum, fill count, prev_pos and watchdog are cleared. z_pos=0, z_vel=0, state_valid=0, warm=0, sensor_fault=0.
- Window: N-deep shift register. Running sum is (16+AVG_LOG2) bits signed. On each accepted sample: sum <= sum + sample_data - oldest, and the window shifts.
- Mean: sum >>> AVG_LOG2, an arithmetic shift (floor toward -inf). It always fits in 16 bits.
- Pipeline: a sample accepted in cycle T updates the window/sum at the edge ending T. Mean and velocity are registered at the next edge. state_valid pulses in cycle T+2 (latency 2). A sample on every cycle is supported with full throughput.
- Velocity: diff = mean - prev_pos as 17-bit signed, then << VEL_SHIFT. The result saturates to [-32768, 32767]. prev_pos <= mean on every output update.
- FILL: samples are accepted and fill count increments, with no state_valid. When the N-th sample is accepted, the state goes to RUN.
- First RUN output: z_pos = mean, z_vel = 0, and prev_pos is seeded with mean. warm rises in the same cycle as this first state_valid.
- RUN: every sample produces one state_valid. The watchdog counts cycles since the last sample_valid.
  - Watchdog reaches TIMEOUT_CYCLES: go to FAULT. sensor_fault=1, warm=0, z_vel=0, and z_pos holds its last value. No state_valid in FAULT.
  - sample_valid in the same cycle the watchdog would reach TIMEOUT_CYCLES: the sample wins, the counter clears and no fault occurs.
- FAULT: the first sample_valid clears the window, sum and fill count. That sample is accepted as fill sample 1 and the state goes to FILL. sensor_fault stays 1 through the re-FILL.
- Leaving re-FILL: sensor_fault clears in the cycle of the first RUN state_valid. That output again has z_vel=0.
- Watchdog in FILL: inactive (counter held at 0). Only RUN can time out.
- Outputs change only on state_valid cycles, FAULT entry, or reset.

Test Plan:
1. Reset: hold rst_n=0 for 10 cycles with sample_valid toggling -> z_pos=0, z_vel=0, state_valid=0, warm=0, sensor_fault=0 throughout.
2. Fill (defaults): feed 4 samples of 100, one every 4 cycles -> no state_valid for samples 1-3. state_valid comes 2 cycles after sample 4 with z_pos=100, z_vel=0, warm=1.
3. Ramp: continue with 104, 108, 112, 116 -> final output z_pos=110, z_vel=4. Repeat with back-to-back samples every cycle -> one state_valid per sample, same final values.
4. Negative rounding: fill with -1, -2, -2, -2 -> z_pos=-2 (floor of -7/4), z_vel=0.
5. Saturation (VEL_SHIFT=2): fill with -32768 x4, then feed 32767 x4 -> every velocity output clamps at 32767. z_pos ends at 32767 with no overflow.
6. Watchdog (TIMEOUT_CYCLES=20): after RUN, stop samples -> at cycle 20 sensor_fault=1, warm=0, z_vel=0, z_pos held. Feed 4 samples of 50 -> first state_valid has z_pos=50, z_vel=0, sensor_fault=0. Rerun with a sample exactly at cycle 20 -> no fault.
